// File: rtl/lsu_pkg.sv
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared encodings, FSM state type, byte-enable constants and the
//           default timeout for the load/store bus controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Reserved size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lo[0];
            default: is_misaligned = (lo != 2'b00);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module  : lsu_lane_align
// Brief   : Combinational byte-lane steering for stores and lane extraction
//           with sign/zero extension for loads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'b00:   byte_sel = rdata_i[7:0];
            2'b01:   byte_sel = rdata_i[15:8];
            2'b10:   byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            SZ_BYTE: begin
                be_o    = BE_BYTE0 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = unsigned_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                be_o    = BE_WORD;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_bus_ctrl.sv
// ============================================================================
// Module  : lsu_bus_ctrl
// Brief   : Load/store unit driving a req/gnt/rvalid data bus with wait
//           states, timeout and core stall. Optional misalignment trap is
//           enabled by defining LSU_MISALIGN_TRAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        misalign;
    logic        timeout;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] ext_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = is_misaligned(req_size_i, req_addr_i[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // Fires on the REQ/WAIT cycle whose increment would reach the limit.
    assign timeout = ({16'd0, cnt_q} + 32'd1) >= TIMEOUT_CYC;

    lsu_lane_align u_align (
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .addr_lo_i  (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata_i),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .rdata_o    (ext_rdata)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid_i) state_d = misalign ? ST_DONE : ST_REQ;
            ST_REQ: begin
                if (mem_gnt_i)    state_d = we_q ? ST_DONE : ST_WAIT;
                else if (timeout) state_d = ST_DONE;
            end
            ST_WAIT: if (mem_rvalid_i || timeout) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            cnt_q      <= 16'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid_i) begin
                    we_q       <= req_we_i;
                    size_q     <= req_size_i;
                    unsigned_q <= req_unsigned_i;
                    addr_q     <= req_addr_i;
                    wdata_q    <= req_wdata_i;
                    cnt_q      <= 16'd0;
                    rdata_q    <= 32'd0;
                    err_q      <= misalign;
                end
                ST_REQ: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (mem_gnt_i) begin
                        if (we_q) err_q <= mem_err_i;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'd0;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (mem_rvalid_i) begin
                        err_q   <= mem_err_i;
                        rdata_q <= mem_err_i ? 32'd0 : ext_rdata;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus and response fields are zero outside their owning state.
    always_comb begin
        req_ready_o = (state_q == ST_IDLE);
        mem_req_o   = (state_q == ST_REQ);
        mem_we_o    = mem_req_o & we_q;
        mem_addr_o  = mem_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_be_o    = mem_req_o ? lane_be : 4'd0;
        mem_wdata_o = mem_req_o ? lane_wdata : 32'd0;
        rsp_valid_o = (state_q == ST_DONE);
        rsp_rdata_o = rsp_valid_o ? rdata_q : 32'd0;
        rsp_err_o   = rsp_valid_o & err_q;
        stall_o     = req_valid_i & ~rsp_valid_o;
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_ctrl.sv
// ============================================================================
// Module  : tb_lsu_bus_ctrl
// Brief   : Directed scoreboard bench for lsu_bus_ctrl; expectations follow
//           LSU_MISALIGN_TRAP_EN when it is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_bus_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_err = 1'b0;

    logic        req_ready, rsp_valid, rsp_err, stall, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    lsu_bus_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .stall_o        (stall),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_be_o       (mem_be),
        .mem_wdata_o    (mem_wdata),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .mem_err_i      (mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    // Monitor: every response pops one expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
                m_e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, m_e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_e.err});
                chk("rsp_cycle", cyc, m_e.cyc);
            end
        end
    end

    task automatic run(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int gdly, input int rdly, input bit nogt,
                       input logic [31:0] rd, input bit berr,
                       input logic [3:0] xbe, input logic [31:0] xwd, input logic [31:0] xaddr,
                       input logic [31:0] xrd, input bit xerr, input int xlat, input int xreq);
        int  k = 0;
        int  w = 0;
        bit  granted = 0;
        bit  seen = 0;
        exp_t e;
        req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        e.rdata = xrd; e.err = xerr; e.cyc = cyc + xlat;
        sb.push_back(e);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; mem_err = 1'b0;
            if (rsp_valid) begin
                chk("stall_done", {31'd0, stall}, 32'd0);
                seen = 1;
                break;
            end
            if (c == 0) chk("stall_busy", {31'd0, stall}, 32'd1);
            if (mem_req && !granted) begin
                if (k == 0) begin
                    chk("mem_be", {28'd0, mem_be}, {28'd0, xbe});
                    chk("mem_wdata", mem_wdata, xwd);
                    chk("mem_addr", mem_addr, xaddr);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, we});
                end
                if (!nogt && k == gdly) begin
                    mem_gnt = 1'b1;
                    granted = 1;
                    if (we) mem_err = berr;
                end
                k++;
            end else if (granted && !we) begin
                if (w == rdly) begin
                    mem_rvalid = 1'b1; mem_rdata = rd; mem_err = berr;
                end
                w++;
            end
        end
        chk("rsp_seen", {31'd0, seen}, 32'd1);
        chk("mem_req_cycles", k, xreq);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Spurious bus handshakes while idle must not produce a response.
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("idle_ready", {31'd0, req_ready}, 32'd1);

        //   we sz     uns addr          wdata         gd rd ng rdata         be  be       xwdata        xaddr         xrdata        xe lat req
        run(1, 2'b00, 0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 0, 32'h0,        0, 4'b1000, 32'hA5A5_A5A5, 32'h0000_1000, 32'h0,        0, 2, 1);
        run(0, 2'b01, 0, 32'h0000_2002, 32'h0,        3, 1, 0, 32'h8001_1234, 0, 4'b1100, 32'h0,        32'h0000_2000, 32'hFFFF_8001, 0, 7, 4);
        run(0, 2'b01, 1, 32'h0000_2002, 32'h0,        3, 1, 0, 32'h8001_1234, 0, 4'b1100, 32'h0,        32'h0000_2000, 32'h0000_8001, 0, 7, 4);
        run(0, 2'b10, 0, 32'h0000_4000, 32'h0,        0, 0, 1, 32'h0,        0, 4'b1111, 32'h0,        32'h0000_4000, 32'h0,        1, 9, 8);
        run(0, 2'b10, 0, 32'h0000_4010, 32'h0,        0, 0, 0, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0,        32'h0000_4010, 32'h0,        1, 3, 1);
        run(1, 2'b10, 0, 32'h0000_5004, 32'h1234_5678, 1, 0, 0, 32'h0,        0, 4'b1111, 32'h1234_5678, 32'h0000_5004, 32'h0,        0, 3, 2);
        run(1, 2'b01, 0, 32'h0000_7002, 32'hFFFF_BEEF, 0, 0, 0, 32'h0,        0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_7000, 32'h0,        0, 2, 1);
        run(0, 2'b00, 1, 32'h0000_6002, 32'h0,        0, 0, 0, 32'h11C3_2233, 0, 4'b0100, 32'h0,        32'h0000_6000, 32'h0000_00C3, 0, 3, 1);
        run(0, 2'b00, 0, 32'h0000_6001, 32'h0,        0, 0, 0, 32'h0000_8000, 0, 4'b0010, 32'h0,        32'h0000_6000, 32'hFFFF_FF80, 0, 3, 1);
        run(0, 2'b10, 0, 32'h0000_9000, 32'h0,        5, 1, 0, 32'hCAFE_F00D, 0, 4'b1111, 32'h0,        32'h0000_9000, 32'hCAFE_F00D, 0, 9, 6);
        run(1, 2'b00, 0, 32'h0000_0100, 32'h0000_005A, 0, 0, 0, 32'h0,        1, 4'b0001, 32'h5A5A_5A5A, 32'h0000_0100, 32'h0,        1, 2, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        run(0, 2'b01, 0, 32'h0000_3001, 32'h0,        0, 0, 0, 32'h1234_ABCD, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        1, 1, 0);
`else
        run(0, 2'b01, 0, 32'h0000_3001, 32'h0,        0, 0, 0, 32'h1234_ABCD, 0, 4'b0011, 32'h0,        32'h0000_3000, 32'hFFFF_ABCD, 0, 3, 1);
`endif

        // Reset while waiting for read data abandons the access.
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_8000; req_wdata = 32'd0; req_valid = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("wait_no_req", {31'd0, mem_req}, 32'd0);
        #2;
        reset = 1'b1; req_valid = 1'b0;
        #1;
        chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", {31'd0, req_ready}, 32'd1);

        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
